// File: rtl/mem_rsp.sv
// Memory responder: services read/write requests from a synchronous array and
// returns read data in order through a 2-entry response buffer; zero-fills the array after reset.
module mem_rsp #(
    parameter int unsigned P_DATA_W   = 24,
    parameter int unsigned P_ADDR_W   = 24,
    parameter int unsigned P_DEPTH_LG = 12
) (
    input  logic                iw_clk,
    input  logic                iw_rst,
    input  logic                iw_req_valid,
    output logic                ow_req_ready,
    input  logic                iw_req_we,
    input  logic [P_ADDR_W-1:0] iw_req_addr,
    input  logic [P_DATA_W-1:0] iw_req_wdata,
    output logic                or_rsp_valid,
    input  logic                iw_rsp_ready,
    output logic [P_DATA_W-1:0] or_rsp_rdata,
    output logic                or_busy_clr
);

    localparam int unsigned LP_DEPTH = 1 << P_DEPTH_LG;

    typedef enum logic {S_CLR, S_RUN} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [P_DEPTH_LG-1:0] r_clr_ptr;
    logic [P_DATA_W-1:0]   r_mem [LP_DEPTH];
    logic [P_DATA_W-1:0]   r_rd_data;
    logic                  r_rd_inflight;
    logic [P_DATA_W-1:0]   r_fifo [2];
    logic                  r_wp;
    logic                  r_rp;
    logic [1:0]            r_cnt;
    logic [P_DATA_W-1:0]   r_hold;

    logic [P_DEPTH_LG-1:0] w_idx;
    logic [1:0]            w_occ;
    logic                  w_accept;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_unused_addr;

    // Upper address bits are don't-care: addresses alias onto the array.
    assign w_idx         = iw_req_addr[P_DEPTH_LG-1:0];
    assign w_unused_addr = ^iw_req_addr[P_ADDR_W-1:P_DEPTH_LG];

    // Ready depends only on registered occupancy, never on iw_rsp_ready.
    assign w_occ        = r_cnt + {1'b0, r_rd_inflight};
    assign ow_req_ready = (r_state == S_RUN) && (w_occ < 2'd2);
    assign w_accept     = iw_req_valid && ow_req_ready;
    assign w_rd_acc     = w_accept && !iw_req_we;
    assign w_wr_acc     = w_accept && iw_req_we;
    assign w_push       = r_rd_inflight;
    assign w_pop        = (r_cnt != 2'd0) && iw_rsp_ready;

    assign or_busy_clr  = (r_state == S_CLR);
    assign or_rsp_valid = (r_cnt != 2'd0);
    assign or_rsp_rdata = (r_cnt != 2'd0) ? r_fifo[r_rp] : r_hold;

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_CLR && r_clr_ptr == '1) begin
            w_state_nxt = S_RUN;
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst) begin
        if (!iw_rst) begin
            r_state       <= S_CLR;
            r_clr_ptr     <= '0;
            r_rd_inflight <= 1'b0;
            r_wp          <= 1'b0;
            r_rp          <= 1'b0;
            r_cnt         <= 2'd0;
            r_hold        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_rd_inflight <= w_rd_acc;
            if (r_state == S_CLR) begin
                r_clr_ptr <= r_clr_ptr + 1'b1;
            end
            if (w_push) begin
                r_wp <= ~r_wp;
            end
            if (w_pop) begin
                r_rp   <= ~r_rp;
                r_hold <= r_fifo[r_rp];
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Array and data path carry no reset; the sweep owns the write port while clearing.
    always_ff @(posedge iw_clk) begin
        if (r_state == S_CLR) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_wr_acc) begin
            r_mem[w_idx] <= iw_req_wdata;
        end
        if (w_rd_acc) begin
            r_rd_data <= r_mem[w_idx];
        end
        if (w_push) begin
            r_fifo[r_wp] <= r_rd_data;
        end
    end

endmodule

// File: tb/tb_mem_rsp.sv
// Directed self-checking bench for mem_rsp with a 16-word array.
module tb_mem_rsp;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [23:0] req_addr;
    logic [23:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [23:0] rsp_rdata;
    logic        busy_clr;

    int checks = 0;
    int errors = 0;

    mem_rsp #(.P_DATA_W(24), .P_ADDR_W(24), .P_DEPTH_LG(4)) dut (
        .iw_clk      (clk),
        .iw_rst      (rst_n),
        .iw_req_valid(req_valid),
        .ow_req_ready(req_ready),
        .iw_req_we   (req_we),
        .iw_req_addr (req_addr),
        .iw_req_wdata(req_wdata),
        .or_rsp_valid(rsp_valid),
        .iw_rsp_ready(rsp_ready),
        .or_rsp_rdata(rsp_rdata),
        .or_busy_clr (busy_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [23:0] wdata;
        logic [23:0] exp;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic we, input logic [23:0] addr, input logic [23:0] wdata);
        int n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 (addr %h)", addr);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic recv(input string nm, input logic [23:0] exp);
        int n = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got rsp_valid=0 expected rsp_valid=1", nm);
        end else begin
            chk(nm, rsp_rdata, exp);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!req_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, {23'd0, req_ready}, 24'd1);
    endtask

    initial begin
        vt[0] = '{1'b1, 24'h000003, 24'h00ABCD, 24'h0};
        vt[1] = '{1'b0, 24'h000003, 24'h0,      24'h00ABCD};
        vt[2] = '{1'b1, 24'h000012, 24'h000055, 24'h0};
        vt[3] = '{1'b0, 24'h000002, 24'h0,      24'h000055};
        vt[4] = '{1'b1, 24'h00000F, 24'hFFFFFF, 24'h0};
        vt[5] = '{1'b0, 24'h00000F, 24'h0,      24'hFFFFFF};
        vt[6] = '{1'b0, 24'hFFFFF3, 24'h0,      24'h00ABCD};
        vt[7] = '{1'b1, 24'h000009, 24'h123456, 24'h0};
        vt[8] = '{1'b0, 24'h000019, 24'h0,      24'h123456};
        vt[9] = '{1'b0, 24'h000005, 24'h0,      24'h000000};

        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 24'h000005;
        req_wdata = 24'h0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  {23'd0, busy_clr},  24'd1);
        chk("rst_ready", {23'd0, req_ready}, 24'd0);
        chk("rst_valid", {23'd0, rsp_valid}, 24'd0);
        chk("rst_rdata", rsp_rdata, 24'd0);

        // Sweep: 16 busy cycles with ready low, ready on cycle 17.
        @(negedge clk);
        rst_n = 1'b1;
        chk("sweep_busy_c1",  {23'd0, busy_clr},  24'd1);
        chk("sweep_ready_c1", {23'd0, req_ready}, 24'd0);
        for (int i = 1; i < 16; i++) begin
            @(posedge clk); #1;
            chk($sformatf("sweep_busy_c%0d", i + 1),  {23'd0, busy_clr},  24'd1);
            chk($sformatf("sweep_ready_c%0d", i + 1), {23'd0, req_ready}, 24'd0);
        end
        @(posedge clk); #1;
        chk("sweep_busy_c17",  {23'd0, busy_clr},  24'd0);
        chk("sweep_ready_c17", {23'd0, req_ready}, 24'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        recv("sweep_read_zero", 24'h0);

        // Read-after-write with exact one-cycle latency.
        send(1'b1, 24'h000003, 24'h00ABCD);
        send(1'b0, 24'h000003, 24'h0);
        chk("raw_valid_n", {23'd0, rsp_valid}, 24'd0);
        @(posedge clk); #1;
        chk("raw_valid_n1", {23'd0, rsp_valid}, 24'd1);
        chk("raw_rdata", rsp_rdata, 24'h00ABCD);
        recv("raw_pop", 24'h00ABCD);

        for (int i = 0; i < 10; i++) begin
            send(vt[i].we, vt[i].addr, vt[i].wdata);
            if (!vt[i].we) recv($sformatf("vec%0d", i), vt[i].exp);
        end

        // Backpressure: only two reads fit while responses are held.
        send(1'b1, 24'h000001, 24'h000111);
        send(1'b1, 24'h000002, 24'h000222);
        send(1'b1, 24'h000003, 24'h000333);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 24'h000001;
        chk("bp_ready0", {23'd0, req_ready}, 24'd1);
        @(posedge clk); #1;
        req_addr = 24'h000002;
        chk("bp_ready1", {23'd0, req_ready}, 24'd1);
        @(posedge clk); #1;
        req_addr = 24'h000003;
        chk("bp_ready2", {23'd0, req_ready}, 24'd0);
        @(posedge clk); #1;
        chk("bp_ready3", {23'd0, req_ready}, 24'd0);
        chk("bp_valid3", {23'd0, rsp_valid}, 24'd1);
        chk("bp_head3",  rsp_rdata, 24'h000111);
        @(posedge clk); #1;
        chk("bp_hold4",  rsp_rdata, 24'h000111);
        chk("bp_ready4", {23'd0, req_ready}, 24'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_head5",  rsp_rdata, 24'h000222);
        chk("bp_ready5", {23'd0, req_ready}, 24'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_empty6", {23'd0, rsp_valid}, 24'd0);
        chk("bp_last6",  rsp_rdata, 24'h000222);
        @(posedge clk); #1;
        chk("bp_valid7", {23'd0, rsp_valid}, 24'd1);
        chk("bp_head7",  rsp_rdata, 24'h000333);
        @(posedge clk); #1;
        chk("bp_empty8", {23'd0, rsp_valid}, 24'd0);
        rsp_ready = 1'b0;

        // Streaming reads: in-order data with the consumer always ready.
        for (int i = 0; i < 8; i++) send(1'b1, 24'(i), 24'h000100 + 24'(i * 17));
        fork
            begin
                for (int i = 0; i < 8; i++) send(1'b0, 24'(i), 24'h0);
            end
            begin
                rsp_ready = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    int n = 0;
                    while (!rsp_valid && n < 20) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    chk($sformatf("stream%0d", i), rsp_valid ? rsp_rdata : 24'hXXXXXX,
                        24'h000100 + 24'(i * 17));
                    @(posedge clk); #1;
                end
                rsp_ready = 1'b0;
            end
        join

        // Reset with a buffered response and a read in flight.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 24'h000009;
        @(posedge clk); #1;
        req_addr = 24'h00000F;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_valid_before", {23'd0, rsp_valid}, 24'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid_after", {23'd0, rsp_valid}, 24'd0);
        chk("mid_rdata_after", rsp_rdata, 24'd0);
        chk("mid_busy_after",  {23'd0, busy_clr}, 24'd1);
        chk("mid_ready_after", {23'd0, req_ready}, 24'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("mid_sweep_done");
        chk("mid_no_stale", {23'd0, rsp_valid}, 24'd0);
        send(1'b0, 24'h000009, 24'h0);
        recv("mid_zero9", 24'h0);
        send(1'b0, 24'h000003, 24'h0);
        recv("mid_zero3", 24'h0);
        send(1'b0, 24'h00000F, 24'h0);
        recv("mid_zeroF", 24'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
